// File: rtl/vec_pack_writer.sv
// vec_pack_writer: packs scalar elements into wide words and writes them to consecutive addresses.
// Optional early termination via in_last when VEC_PACK_LAST_EN is defined.
module vec_pack_writer #(
  parameter int element_width = 64,
  parameter int no_of_units   = 8,
  parameter int address_width = 20,
  parameter int count_width   = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [address_width-1:0]             base_address,
  input  logic [count_width-1:0]               word_count,
  input  logic [element_width-1:0]             in_data,
  input  logic                                 in_valid,
`ifdef VEC_PACK_LAST_EN
  input  logic                                 in_last,
`endif
  output logic                                 in_ready,
  output logic                                 write_enable,
  output logic [address_width-1:0]             input_write_address,
  output logic [no_of_units*element_width-1:0] input_data,
  output logic                                 busy,
  output logic                                 finish
);
  localparam int DW = no_of_units * element_width;
  localparam int LW = (no_of_units > 1) ? $clog2(no_of_units) : 1;
  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;
  state_t r_state, w_next;
  logic [LW-1:0] r_lane;
  logic [count_width-1:0] r_word, r_cnt;
  logic [address_width-1:0] r_base;
  logic [DW-1:0] r_buf, w_buf;
  logic w_accept, w_end, w_stop;
  assign w_accept = (r_state == FILL) && in_valid;
`ifdef VEC_PACK_LAST_EN
  logic r_term;
  assign w_end  = (r_lane == LW'(no_of_units - 1)) || in_last;
  assign w_stop = (r_word == r_cnt - count_width'(1)) || r_term;
  always_ff @(posedge clk or posedge reset)
    if (reset) r_term <= 1'b0;
    else if (r_state == IDLE && start) r_term <= 1'b0;
    else if (w_accept) r_term <= in_last;
`else
  assign w_end  = r_lane == LW'(no_of_units - 1);
  assign w_stop = r_word == r_cnt - count_width'(1);
`endif
  always_comb begin
    w_buf = r_buf;
    w_buf[r_lane*element_width +: element_width] = in_data;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? ((word_count == '0) ? DONE : FILL) : IDLE;
      FILL:    w_next = (w_accept && w_end) ? WRITE : FILL;
      WRITE:   w_next = w_stop ? DONE : FILL;
      default: w_next = IDLE;
    endcase
  end
  // Output flags are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state             <= IDLE;
      in_ready            <= 1'b0;
      write_enable        <= 1'b0;
      busy                <= 1'b0;
      finish              <= 1'b0;
      input_write_address <= '0;
      input_data          <= '0;
      r_lane              <= '0;
      r_word              <= '0;
      r_cnt               <= '0;
      r_base              <= '0;
      r_buf               <= '0;
    end else begin
      r_state      <= w_next;
      in_ready     <= w_next == FILL;
      write_enable <= w_next == WRITE;
      busy         <= w_next != IDLE;
      finish       <= w_next == DONE;
      if (r_state == IDLE && start) begin
        r_base <= base_address;
        r_cnt  <= word_count;
        r_lane <= '0;
        r_word <= '0;
        r_buf  <= '0;
      end
      if (w_accept) begin
        r_buf  <= w_buf;
        r_lane <= r_lane + LW'(1);
      end
      if (w_accept && w_end) begin
        input_data          <= w_buf;
        input_write_address <= r_base + address_width'(r_word);
      end
      // Clearing the buffer after each write zero-fills lanes of an early-terminated word.
      if (r_state == WRITE) begin
        r_word <= r_word + count_width'(1);
        r_lane <= '0;
        r_buf  <= '0;
      end
    end
endmodule

// File: tb/tb_vec_pack_writer.sv
// tb_vec_pack_writer: randomized stimulus against a queue-based model of the expected memory writes.
module tb_vec_pack_writer;
  localparam int EW = 64, NU = 8, AW = 20, CW = 16, DW = NU * EW;
  typedef struct packed {logic [AW-1:0] a; logic [DW-1:0] d;} wr_t;
  logic clk = 0, reset = 1, start = 0, in_valid = 0;
  logic [AW-1:0] base_address = '0;
  logic [CW-1:0] word_count = '0;
  logic [EW-1:0] in_data = '0;
`ifdef VEC_PACK_LAST_EN
  logic in_last = 0;
`endif
  logic in_ready, write_enable, busy, finish;
  logic [AW-1:0] input_write_address;
  logic [DW-1:0] input_data;
  int checks = 0, errors = 0, n_wr = 0, n_fin = 0;
  bit prev_fin = 0;
  wr_t exp_q[$];
  logic [EW-1:0] elems[$];

  vec_pack_writer dut (
    .clk(clk), .reset(reset), .start(start), .base_address(base_address),
    .word_count(word_count), .in_data(in_data), .in_valid(in_valid),
`ifdef VEC_PACK_LAST_EN
    .in_last(in_last),
`endif
    .in_ready(in_ready), .write_enable(write_enable),
    .input_write_address(input_write_address), .input_data(input_data),
    .busy(busy), .finish(finish)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (write_enable) begin
      n_wr++;
      if (exp_q.size() == 0) chk("unexpected_write", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("write_addr", DW'(input_write_address), DW'(e.a));
        chk("write_data", input_data, e.d);
      end
    end
    if (finish) begin
      n_fin++;
      chk("finish_one_cycle", DW'(prev_fin), 0);
    end
    prev_fin = finish;
  end

  task automatic gen(input int n_el, input bit fixed, input logic [AW-1:0] base);
    logic [DW-1:0] w;
    elems.delete();
    for (int i = 0; i < n_el; i++) elems.push_back(fixed ? EW'(i + 1) : {$urandom, $urandom});
    for (int k = 0; k * NU < n_el; k++) begin
      w = '0;
      for (int l = 0; l < NU && k * NU + l < n_el; l++) w[l*EW +: EW] = elems[k*NU+l];
      exp_q.push_back('{a: base + AW'(k), d: w});
    end
  endtask

  task automatic feed(input int n_el, input int last_at, input bit hold);
    int idx, cyc;
    bit acc;
    idx = 0;
    cyc = 0;
    while (idx < n_el && cyc < 2000) begin
      in_valid = hold || ($urandom_range(0, 2) != 0);
      in_data = elems[idx];
`ifdef VEC_PACK_LAST_EN
      in_last = idx == last_at;
`endif
      acc = in_valid && in_ready;
      @(negedge clk);
      cyc++;
      if (acc) idx++;
      chk("we_timing", DW'(write_enable), DW'(acc && (idx % NU == 0 || idx == last_at + 1)));
    end
    in_valid = 0;
`ifdef VEC_PACK_LAST_EN
    in_last = 0;
`endif
    if (idx < n_el) chk("feed_timeout", DW'(idx), DW'(n_el));
  endtask

  task automatic run(input logic [AW-1:0] base, input int cnt, input int last_at, input bit hold, input bit fixed);
    int n_el, nw, w0, f0;
    n_el = last_at >= 0 ? last_at + 1 : cnt * NU;
    nw = (n_el + NU - 1) / NU;
    gen(n_el, fixed, base);
    w0 = n_wr;
    f0 = n_fin;
    @(negedge clk);
    start = 1;
    base_address = base;
    word_count = CW'(cnt);
    @(negedge clk);
    start = 0;
    chk("busy_after_start", DW'(busy), 1);
    if (cnt == 0) begin
      chk("zero_finish", DW'(finish), 1);
      chk("zero_ready", DW'(in_ready), 0);
    end else begin
      feed(n_el, last_at, hold);
      @(negedge clk);
      chk("finish_pulse", DW'(finish), 1);
      chk("busy_in_done", DW'(busy), 1);
    end
    @(negedge clk);
    chk("finish_low", DW'(finish), 0);
    chk("busy_idle", DW'(busy), 0);
    chk("ready_idle", DW'(in_ready), 0);
    chk("write_count", DW'(n_wr - w0), DW'(nw));
    chk("finish_count", DW'(n_fin - f0), 1);
  endtask

  initial begin
    int w0, f0;
    repeat (2) @(negedge clk);
    chk("rst_we", DW'(write_enable), 0);
    chk("rst_ready", DW'(in_ready), 0);
    chk("rst_busy", DW'(busy), 0);
    chk("rst_finish", DW'(finish), 0);
    chk("rst_addr", DW'(input_write_address), 0);
    chk("rst_data", input_data, 0);
    reset = 0;
    gen(NU, 1, 20'h10);
    chk("model_pin_data", exp_q[0].d, {64'd8, 64'd7, 64'd6, 64'd5, 64'd4, 64'd3, 64'd2, 64'd1});
    chk("model_pin_addr", DW'(exp_q[0].a), DW'(20'h10));
    exp_q.delete();
    gen(2 * NU, 0, 20'hFFFFF);
    chk("model_pin_wrap", DW'(exp_q[1].a), 0);
    exp_q.delete();
    run(20'h10, 1, -1, 1, 1);
    run(20'h100, 3, -1, 0, 0);
    run(20'h55, 0, -1, 0, 0);
    run(20'hFFFFF, 2, -1, 1, 0);
    gen(NU + 5, 0, 20'h200);
    w0 = n_wr;
    f0 = n_fin;
    @(negedge clk);
    start = 1;
    base_address = 20'h200;
    word_count = 3;
    @(negedge clk);
    start = 0;
    feed(NU + 5, -1, 0);
    reset = 1;
    #1;
    chk("rst_mid_we", DW'(write_enable), 0);
    chk("rst_mid_busy", DW'(busy), 0);
    chk("rst_mid_ready", DW'(in_ready), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 0;
    chk("rst_mid_writes", DW'(n_wr - w0), 1);
    chk("rst_mid_finish", DW'(n_fin - f0), 0);
    run(20'h10, 1, -1, 1, 1);
    for (int i = 0; i < 5; i++)
      run(AW'($urandom), $urandom_range(1, 4), -1, 1'($urandom_range(0, 1)), 0);
`ifdef VEC_PACK_LAST_EN
    run(20'h300, 4, NU + 2, 0, 0);
`endif
    chk("queue_empty", DW'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
